// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: main + skid buffered valid/ready handshake with
// synchronous flush. Load/store address exceptions are classified when a beat
// is accepted and travel with it.
// Optional build macro: EX_MEM_BADVADDR_EN adds badvaddr_out (faulting address).
module ex_mem_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_CMP_W   = 16,
  parameter logic [ADDR_CMP_W-1:0] DM_LIMIT  = 16'h2fff,
  parameter logic [ADDR_CMP_W-1:0] DEV0_BASE = 16'h7f00,
  parameter logic [ADDR_CMP_W-1:0] DEV1_BASE = 16'h7f10,
  parameter int unsigned DEV_RD_BYTES = 12,
  parameter int unsigned DEV_WR_BYTES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mem_op,
  input  logic [DATA_W-1:0] ao_in,
  input  logic [DATA_W-1:0] wdm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] pcadd8_in,
  input  logic [DATA_W-1:0] hilo_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ao_out,
  output logic [DATA_W-1:0] wdm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pcadd8_out,
  output logic [DATA_W-1:0] hilo_out,
  output logic [3:0]        mem_op_out,
  output logic [4:0]        exc_out
`ifdef EX_MEM_BADVADDR_EN
  ,
  output logic [DATA_W-1:0] badvaddr_out
`endif
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
    OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8
  } mem_op_e;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5
  } exc_e;

  typedef struct packed {
    logic [DATA_W-1:0] ao;
    logic [DATA_W-1:0] wdm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcadd8;
    logic [DATA_W-1:0] hilo;
    logic [3:0]        op;
    logic [4:0]        exc;
`ifdef EX_MEM_BADVADDR_EN
    logic [DATA_W-1:0] badv;
`endif
  } beat_t;

  // One extra bit so base+size never wraps in the window compares.
  localparam int unsigned AW = ADDR_CMP_W + 1;
  localparam logic [AW-1:0] LIMIT_X = {1'b0, DM_LIMIT};
  localparam logic [AW-1:0] D0_X    = {1'b0, DEV0_BASE};
  localparam logic [AW-1:0] D1_X    = {1'b0, DEV1_BASE};
  localparam logic [AW-1:0] RD_X    = AW'(DEV_RD_BYTES);
  localparam logic [AW-1:0] WR_X    = AW'(DEV_WR_BYTES);

  logic          is_load, is_store, is_word, is_half, is_sub;
  logic [AW-1:0] a_x, lim_x;
  logic          misalign, in_dev_acc, in_dev_rd, bad;
  exc_e          exc_c;
  beat_t         in_beat;

  logic  m_valid, s_valid, rdy_q;
  beat_t m_data, s_data;
  logic  m_valid_d, s_valid_d;
  beat_t m_data_d, s_data_d;
  logic  accept, fire;

  // Classify the incoming beat's address against alignment, range and device rules.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    is_sub   = 1'b0;
    case (mem_op_e'(mem_op))
      OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; is_sub = 1'b1; end
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_sub  = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; is_sub = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_sub  = 1'b1; end
      default:       ;
    endcase
    a_x        = {1'b0, ao_in[ADDR_CMP_W-1:0]};
    lim_x      = is_store ? WR_X : RD_X;
    misalign   = (is_word && (a_x[1:0] != 2'b00)) || (is_half && a_x[0]);
    in_dev_acc = (a_x >= D0_X && a_x < D0_X + lim_x) || (a_x >= D1_X && a_x < D1_X + lim_x);
    in_dev_rd  = (a_x >= D0_X && a_x < D0_X + RD_X)  || (a_x >= D1_X && a_x < D1_X + RD_X);
    bad        = misalign || (a_x > LIMIT_X && !in_dev_acc) || (is_sub && in_dev_rd);
    exc_c      = EXC_NONE;
    if (bad && is_store)     exc_c = EXC_ADES;
    else if (bad && is_load) exc_c = EXC_ADEL;

    in_beat        = '0;
    in_beat.ao     = ao_in;
    in_beat.wdm    = wdm_in;
    in_beat.pc     = pc_in;
    in_beat.pcadd8 = pcadd8_in;
    in_beat.hilo   = hilo_in;
    in_beat.op     = mem_op;
    in_beat.exc    = exc_c;
`ifdef EX_MEM_BADVADDR_EN
    in_beat.badv   = (exc_c != EXC_NONE) ? ao_in : '0;
`endif
  end

  assign accept = in_valid && rdy_q;
  assign fire   = m_valid && out_ready;

  // Main/skid steering: M refills from S first, else from the input; a held M parks input in S.
  always_comb begin
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    m_data_d  = m_data;
    s_data_d  = s_data;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid || fire) begin
      if (s_valid) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
        s_valid_d = accept;
        if (accept) s_data_d = in_beat;
      end else begin
        m_valid_d = accept;
        s_valid_d = 1'b0;
        if (accept) m_data_d = in_beat;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_beat;
    end
  end

  // Buffer state; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy_q   <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else begin
      m_valid <= m_valid_d;
      s_valid <= s_valid_d;
      rdy_q   <= !s_valid_d;
      m_data  <= m_data_d;
      s_data  <= s_data_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = m_valid;
  assign ao_out     = m_data.ao;
  assign wdm_out    = m_data.wdm;
  assign pc_out     = m_data.pc;
  assign pcadd8_out = m_data.pcadd8;
  assign hilo_out   = m_data.hilo;
  assign mem_op_out = m_valid ? m_data.op  : '0;
  assign exc_out    = m_valid ? m_data.exc : '0;
`ifdef EX_MEM_BADVADDR_EN
  assign badvaddr_out = m_valid ? m_data.badv : '0;
`else
  // Faulting address is not captured in this build.
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX→MEM pipeline stage: registers execute-stage results and classifies load/store address exceptions at capture.
- Adds a valid/ready handshake with a 2-entry buffer (main + skid), so a MEM-side stall does not combinationally reach EX.
- Adds a synchronous flush for branch/exception redirect.
- Sits between the ALU/MDU stage and data memory / device bridge.

Parameters:
- DATA_W, 32, width of every payload field.
- ADDR_CMP_W, 16, low address bits used for the range check.
- DM_LIMIT, 16'h2fff, highest valid data-memory byte address.
- DEV0_BASE, 16'h7f00, base of device window 0.
- DEV1_BASE, 16'h7f10, base of device window 1.
- DEV_RD_BYTES, 12, readable bytes per device window.
- DEV_WR_BYTES, 8, writable bytes per device window.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- flush  in  1  drop all buffered and incoming beats.
- in_valid  in  1  EX presents a beat.
- in_ready  out  1  stage can accept a beat.
- mem_op  in  4  access type: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none.
- ao_in, wdm_in, pc_in, pcadd8_in, hilo_in  in  DATA_W each  EX payload.
- out_valid  out  1  MEM beat valid.
- out_ready  in  1  MEM consumes the beat.
- ao_out, wdm_out, pc_out, pcadd8_out, hilo_out  out  DATA_W each  registered payload.
- mem_op_out  out  4  registered mem_op.
- exc_out  out  5  0 none, 4 AdEL, 5 AdES.

Behaviour:
- Reset (async): both entries invalid; out_valid=0; all payload outputs, mem_op_out and exc_out =0; in_ready=1 from the first clock after reset deasserts.
- Storage: main entry M drives the outputs; skid entry S. in_ready is registered: in_ready = !S.valid.
- Accept on (in_valid & in_ready). Fire on (out_valid & out_ready).
- Latency: 1 cycle when unstalled. A beat accepted at edge n appears at out_* after edge n.
- Per edge, when flush=0:
  - M empty or firing: M takes S if S is valid, else M takes the accepted beat; S takes nothing.
  - M held (not firing): an accepted beat goes to S.
  - When M takes S and a beat is accepted in the same cycle, the beat goes into S.
- Order is preserved; a beat is never duplicated or dropped.
- flush=1: M and S are invalidated at the edge. An accept in the same cycle is discarded. out_valid=0 and in_ready=1 on the next cycle. flush has priority over everything.
- Exception classification is computed from ao_in/mem_op at accept and stored with the beat (exc_out is registered, never combinational on ao_out). a = ao_in[ADDR_CMP_W-1:0].
  - Misaligned: lw/sw with a[1:0]≠0; lh/lhu/sh with a[0]≠0.
  - Out of range: a>DM_LIMIT and a is outside both device windows [DEVx_BASE, DEVx_BASE+limit-1]. limit = DEV_RD_BYTES for loads, DEV_WR_BYTES for stores.
  - Sub-word to device: lh/lhu/lb/lbu/sh/sb with a inside either window's [base, base+DEV_RD_BYTES-1].
  - Store → 5, load → 4, mem_op none → 0. The address-bit-only check is the decided behaviour; upper address bits are ignored.
- Payload of invalid entries is don't-care, except: exc_out and mem_op_out are forced to 0 while out_valid=0, so a stale exception is never flagged.
- Outputs hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: EX_MEM_BADVADDR_EN.
- Defined: adds output badvaddr_out [DATA_W-1:0], stored per entry. It equals the full ao_in of a beat whose exc≠0, and 0 otherwise; it is forced to 0 when out_valid=0. Reset value 0.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset mid-stream with both entries full → out_valid=0, exc_out=0, ao_out=0 immediately (async); in_ready=1 one clock after release.
- lw at ao=0x00000004, out_ready=1 → next cycle out_valid=1, ao_out=0x4, exc_out=0. sw at 0x00000006 → exc_out=5. lh at 0x00000003 → exc_out=4.
- Range checks:
  - sw 0x7f08 → 5; lw 0x7f08 → 0.
  - lw 0x7f0c → 4; lw 0x7f1b → 4 (misaligned).
  - sb 0x7f10 → 5; lbu 0x3000 → 4; lb 0x2fff → 0.
- Stall: out_ready=0 while 3 beats are offered back-to-back → beats 1,2 accepted, in_ready=0 during the cycle beat 3 is offered. On release, outputs follow in order 1,2 and then 3 once it is accepted; no loss or duplication.
- Flush asserted with M and S full plus in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed beats never appear.
- With EX_MEM_BADVADDR_EN: sh at 0x12347f01 → exc_out=5, badvaddr_out=0x12347f01. A following lw at 0x0 → badvaddr_out=0.
